// File: rtl/nvdla_dbb_rd_arbiter.sv
// ----------------------------------------------------------------------------
// nvdla_dbb_rd_arbiter
//
// Shares one DBB AXI read channel (AR/R) between two read masters.
//   * AR: the two master requests are arbitrated into a single output register
//     (s_ar*). Each accepted ID has its MSB replaced by the master index.
//   * R:  beats are routed combinationally to the master named by s_rid MSB;
//     the tag bit is cleared on the way back.
//   * Each master may hold at most MAX_OUTST bursts in flight. A burst counts
//     from its AR handshake until its rlast beat.
//
// Ports
//   dla_core_clk, dla_reset_rstn   clock, synchronous active-low reset
//   m0_ar*/m1_ar*                  master AR channels (arready is combinational)
//   m0_r*/m1_r*                    master R channels (routed from s_r*)
//   s_ar*                          registered downstream AR channel
//   s_r*                           downstream R channel
//   arb_idle                       AR register empty and nothing outstanding
//
// Configuration
//   NVDLA_DBB_ARB_FIXED_PRIO_EN    when defined, M0 always wins (no RR pointer);
//                                  otherwise round robin between the masters.
// ----------------------------------------------------------------------------
module nvdla_dbb_rd_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 8,
    parameter int MAX_OUTST = 16
) (
    input  logic              dla_core_clk,
    input  logic              dla_reset_rstn,
    // master 0 AR / R
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [LEN_W-1:0]  m0_arlen,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rlast,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    // master 1 AR / R
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [LEN_W-1:0]  m1_arlen,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rlast,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    // downstream AR
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ID_W-1:0]   s_arid,
    output logic [LEN_W-1:0]  s_arlen,
    output logic [ADDR_W-1:0] s_araddr,
    // downstream R
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic              s_rlast,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    // status
    output logic              arb_idle
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic              r_s_arvalid;
    logic [ID_W-1:0]   r_s_arid;
    logic [LEN_W-1:0]  r_s_arlen;
    logic [ADDR_W-1:0] r_s_araddr;

    logic       w_load_en;
    logic       w_r_hs;
    logic [1:0] w_arvalid;
    logic [1:0] w_arid_msb;
    logic [1:0] w_elig;
    logic [1:0] w_grant;
    logic [1:0] w_ar_hs;
    logic [1:0] w_r_done;
    logic [1:0] w_cnt_zero;

    // The AR register can take a new request when empty or when it is being
    // drained this very cycle, which gives back-to-back issue.
    assign w_load_en  = !r_s_arvalid || s_arready;
    assign w_arvalid  = {m1_arvalid, m0_arvalid};
    assign w_arid_msb = {m1_arid[ID_W-1], m0_arid[ID_W-1]};
    assign w_r_hs     = s_rvalid && s_rready;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef NVDLA_DBB_ARB_FIXED_PRIO_EN
    assign w_grant[0] = w_elig[0];
    assign w_grant[1] = w_elig[1] && !w_elig[0];
`else
    // r_rr_ptr = 0 favours M0, 1 favours M1. It only moves when a grant is
    // actually captured, and always moves away from the granted master.
    logic r_rr_ptr;

    assign w_grant[0] = w_elig[0] && (!w_elig[1] || !r_rr_ptr);
    assign w_grant[1] = w_elig[1] && (!w_elig[0] ||  r_rr_ptr);

    always_ff @(posedge dla_core_clk) begin
        if (!dla_reset_rstn) begin
            r_rr_ptr <= 1'b0;
        end else if (w_load_en && (|w_grant)) begin
            r_rr_ptr <= w_grant[0];
        end
    end
`endif

    // arready is masked during reset so nothing is accepted while state is cleared.
    assign w_ar_hs    = w_grant & {2{w_load_en && dla_reset_rstn}};
    assign m0_arready = w_ar_hs[0];
    assign m1_arready = w_ar_hs[1];

    // ------------------------------------------------------------------
    // Per-master outstanding burst counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic [CNT_W-1:0] r_cnt;

            assign w_elig[gi]     = w_arvalid[gi] && (r_cnt < MAX_CNT);
            assign w_r_done[gi]   = w_r_hs && s_rlast && (s_rid[ID_W-1] == 1'(gi));
            assign w_cnt_zero[gi] = (r_cnt == '0);

            // Simultaneous issue and retire leaves the count unchanged.
            always_ff @(posedge dla_core_clk) begin
                if (!dla_reset_rstn) begin
                    r_cnt <= '0;
                end else if (w_ar_hs[gi] && !w_r_done[gi] && (r_cnt != MAX_CNT)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (!w_ar_hs[gi] && w_r_done[gi] && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end

`ifndef SYNTHESIS
            always_ff @(posedge dla_core_clk) begin
                if (dla_reset_rstn) begin
                    assert (!(w_r_done[gi] && !w_ar_hs[gi] && (r_cnt == '0)))
                        else $error("nvdla_dbb_rd_arbiter: outstanding underflow on master %0d", gi);
                    assert (!(w_arvalid[gi] && w_arid_msb[gi]))
                        else $error("nvdla_dbb_rd_arbiter: master %0d drove arid MSB high", gi);
                end
            end
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // AR output register; holds stable while stalled by s_arready.
    // ------------------------------------------------------------------
    always_ff @(posedge dla_core_clk) begin
        if (!dla_reset_rstn) begin
            r_s_arvalid <= 1'b0;
            r_s_arid    <= '0;
            r_s_arlen   <= '0;
            r_s_araddr  <= '0;
        end else if (w_load_en) begin
            r_s_arvalid <= |w_grant;
            if (w_grant[1]) begin
                r_s_arid   <= {1'b1, m1_arid[ID_W-2:0]};
                r_s_arlen  <= m1_arlen;
                r_s_araddr <= m1_araddr;
            end else if (w_grant[0]) begin
                r_s_arid   <= {1'b0, m0_arid[ID_W-2:0]};
                r_s_arlen  <= m0_arlen;
                r_s_araddr <= m0_araddr;
            end
        end
    end

    assign s_arvalid = r_s_arvalid;
    assign s_arid    = r_s_arid;
    assign s_arlen   = r_s_arlen;
    assign s_araddr  = r_s_araddr;

    // ------------------------------------------------------------------
    // R routing by tag bit
    // ------------------------------------------------------------------
    assign m0_rvalid = s_rvalid && !s_rid[ID_W-1];
    assign m1_rvalid = s_rvalid &&  s_rid[ID_W-1];
    assign s_rready  = s_rid[ID_W-1] ? m1_rready : m0_rready;
    assign m0_rid    = {1'b0, s_rid[ID_W-2:0]};
    assign m1_rid    = {1'b0, s_rid[ID_W-2:0]};
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;

    assign arb_idle = !r_s_arvalid && (&w_cnt_zero);

endmodule
